// File: rtl/instenc_loader.sv
// Field-to-word instruction encoder feeding a sequential instruction-RAM loader.
// Define INSTENC_BRANCH_EN to accept opcode 001 (conditional branch) bundles.
module instenc_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        opcode,
    input  logic [1:0]        op,
    input  logic [2:0]        rn,
    input  logic [2:0]        rd,
    input  logic [1:0]        shift,
    input  logic [2:0]        rm,
    input  logic [7:0]        imm8,
    input  logic [4:0]        imm5,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FULL} state_t;

    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;

    logic              enc_legal;
    logic [15:0]       enc_word;

    // Field packing; anything not matched below is an illegal bundle.
    always_comb begin
        enc_legal = 1'b0;
        enc_word  = 16'h0000;
        case (opcode)
            3'b110: begin
                if (op == 2'b10) begin
                    enc_legal = 1'b1;
                    enc_word  = {opcode, op, rn, imm8};
                end else if (op == 2'b00) begin
                    enc_legal = 1'b1;
                    enc_word  = {opcode, op, 3'b000, rd, shift, rm};
                end
            end
            3'b101: begin
                enc_legal = 1'b1;
                enc_word  = {opcode, op,
                             (op == 2'b11) ? 3'b000 : rn,
                             (op == 2'b01) ? 3'b000 : rd,
                             shift, rm};
            end
            3'b011, 3'b100: begin
                if (op == 2'b00) begin
                    enc_legal = 1'b1;
                    enc_word  = {opcode, op, rn, rd, imm5};
                end
            end
            3'b111: begin
                if (op == 2'b00) begin
                    enc_legal = 1'b1;
                    enc_word  = {opcode, op, 11'b0};
                end
            end
`ifdef INSTENC_BRANCH_EN
            3'b001: begin
                if (op == 2'b00) begin
                    enc_legal = 1'b1;
                    enc_word  = {opcode, op, rn, imm8};
                end
            end
`else
            3'b001: enc_legal = 1'b0;
`endif
            default: enc_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = err_q;
        if (clear) begin
            state_d = S_IDLE;
            addr_d  = BASE_C;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (enc_legal) begin
                            wdata_d = enc_word;
                            state_d = S_WRITE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    count_d = count_q + 1'b1;
                    // Saturate rather than wrap when the window ends at the top of the address space.
                    if (addr_q != {ADDR_W{1'b1}}) begin
                        addr_d = addr_q + 1'b1;
                    end
                    state_d = (count_d == DEPTH_C) ? S_FULL : S_IDLE;
                end
                S_FULL:  state_d = S_FULL;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= BASE_C;
            wdata_q <= 16'h0000;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // A clear arriving during the write cycle suppresses the strobe.
    assign mem_we    = (state_q == S_WRITE) && !clear;
    assign in_ready  = (state_q == S_IDLE);
    assign full      = (state_q == S_FULL);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign err       = err_q;

endmodule
